uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares the single UART transmitter among NREQ byte producers.
- Selects one requester, latches its byte and drives the transmitter's data_in/transmit pair.
- Confirms acceptance via tx_busy, then waits for the frame to finish before serving the next requester.
- Sits between client logic and the uart_tx instance.

Parameters:
NREQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
START_TIMEOUT, 65535, clk cycles to wait for tx_busy rise after transmit asserted before aborting

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
req  input  NREQ  per-requester send request, level; hold with data stable until ack
req_data  input  NREQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W]
ack  output  NREQ  one-cycle pulse: requester's byte accepted by transmitter
timeout_err  output  1  one-cycle pulse: start not accepted within START_TIMEOUT
uart_data_in  output  DATA_W  byte to transmitter, registered
uart_transmit  output  1  transmit request to transmitter, registered
uart_tx_busy  input  1  transmitter busy flag
active_id  output  $clog2(NREQ)  index of current/last granted requester
ctl_busy  output  1  high in any state except IDLE

Behaviour:
- All outputs are registered. Reset is sampled only on a clk edge with reset=0.
- Reset values: ack=0, timeout_err=0, uart_data_in=0, uart_transmit=0, active_id=0, ctl_busy=0.
- Reset also sets state=IDLE, rr pointer=NREQ-1 (so requester 0 wins first) and timer=0.
- Reset mid-frame: uart_transmit drops at that edge. The in-flight UART frame is not aborted. After reset, IDLE waits for uart_tx_busy=0 before starting.
- IDLE:
  - Start condition: |req=1 and uart_tx_busy=0.
  - Winner = first set req bit searching from rr+1 upward, modulo NREQ.
  - At the edge: latch winner's byte into uart_data_in, set active_id=winner, set rr=winner, set uart_transmit=1, clear timer, go to START.
  - Latency: req seen in cycle N means uart_transmit=1 in cycle N+1.
  - If uart_tx_busy=1, stay in IDLE regardless of req.
- START:
  - uart_transmit stays 1; timer increments every cycle.
  - On uart_tx_busy=1: pulse ack[active_id] for one cycle, set uart_transmit=0, go to SEND.
  - Else on timer=START_TIMEOUT-1: pulse timeout_err, set uart_transmit=0, go to GAP with no ack.
  - If the requester deasserts req while in START, the latched byte is still sent and ack still pulses.
- SEND: wait for uart_tx_busy=0, then go to GAP. No timeout applies.
- GAP: one cycle with uart_transmit=0, then go to IDLE. This guarantees at least one low cycle of transmit between frames.
- Fairness: the winner becomes lowest priority next arbitration, even on timeout. With all req high, grant order is 0,1,2,3,0...
- uart_data_in holds its value until the next grant.
- Multiple requests in the same cycle: exactly one grant; the others wait with no loss.
- ack is never asserted for more than one requester per cycle.
- Timer width is $clog2(START_TIMEOUT+1). The timer never wraps because START exits at the limit.

Test Plan:
- Reset, then req=4'b0001 with byte 0x55 and the transmitter model raising busy 3 cycles after transmit: uart_transmit=1 the cycle after req, uart_data_in=0x55, ack[0] one pulse when busy rises, transmit=0 next, active_id=0; after busy falls, ctl_busy=0 two cycles later.
- req=4'b1111 held with bytes 0xA0..0xA3: four frames in order 0xA0,0xA1,0xA2,0xA3, then 0xA0 again; acks pulse on bits 0,1,2,3,0 in sequence.
- req=4'b0101 simultaneously after a grant to 0: requester 2 is served before 0; 0 is served next.
- START_TIMEOUT=16 and busy never rises: timeout_err pulses exactly 16 cycles after transmit asserts, no ack, transmit=0; rr advances so req 1 wins the next arbitration.
- uart_tx_busy=1 at reset release with req=4'b0010: no transmit until busy=0; grant to 1 the cycle after.
- reset=0 asserted for one edge in SEND: all outputs return to reset values at that edge; the new arbitration waits for busy=0 and starts from requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester bundle (req, req_data, ack, timeout_err, active_id, ctl_busy) plus uart_tx handshake (uart_data_in, uart_transmit, uart_tx_busy); slave = arbiter side
interface uart_tx_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 8
);
  logic [NREQ-1:0]         req;
  logic [NREQ*DATA_W-1:0]  req_data;
  logic [NREQ-1:0]         ack;
  logic                    timeout_err;
  logic [DATA_W-1:0]       uart_data_in;
  logic                    uart_transmit;
  logic                    uart_tx_busy;
  logic [$clog2(NREQ)-1:0] active_id;
  logic                    ctl_busy;
  modport master (
    output req, req_data, uart_tx_busy,
    input  ack, timeout_err, uart_data_in, uart_transmit, active_id, ctl_busy
  );
  modport slave (
    input  req, req_data, uart_tx_busy,
    output ack, timeout_err, uart_data_in, uart_transmit, active_id, ctl_busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx among NREQ byte producers; ports clk, reset (sync active-low), bus (uart_tx_arbiter_if.slave)
module uart_tx_arbiter #(
  parameter int NREQ          = 4,
  parameter int DATA_W        = 8,
  parameter int START_TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;
  state_t            state, state_n;
  logic [IW-1:0]     rr, rr_n, win, k, id_n;
  logic [TW-1:0]     timer, timer_n;
  logic [NREQ-1:0]   ack_n;
  logic [DATA_W-1:0] data_n;
  logic              tx_n, terr_n, go, tmo;
  assign go  = |bus.req && !bus.uart_tx_busy;
  assign tmo = timer == TW'(START_TIMEOUT - 1);
  always_comb begin
    win = rr;
    k = rr;
    for (int i = NREQ; i >= 1; i--) begin
      k = IW'((int'(rr) + i) % NREQ);
      if (bus.req[k]) win = k;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = go ? START : IDLE;
      START:   state_n = bus.uart_tx_busy ? SEND : tmo ? GAP : START;
      SEND:    state_n = bus.uart_tx_busy ? SEND : GAP;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    rr_n = rr;
    id_n = bus.active_id;
    data_n = bus.uart_data_in;
    timer_n = timer;
    tx_n = 1'b0;
    ack_n = '0;
    terr_n = 1'b0;
    case (state)
      IDLE: if (go) begin
        rr_n = win;
        id_n = win;
        data_n = bus.req_data[win*DATA_W +: DATA_W];
        tx_n = 1'b1;
        timer_n = '0;
      end
      START: begin
        timer_n = timer + 1'b1;
        ack_n = bus.uart_tx_busy ? NREQ'(1) << bus.active_id : '0;
        terr_n = !bus.uart_tx_busy && tmo;
        tx_n = !bus.uart_tx_busy && !tmo;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      rr <= IW'(NREQ - 1);
      timer <= '0;
      bus.ack <= '0;
      bus.timeout_err <= 1'b0;
      bus.uart_data_in <= '0;
      bus.uart_transmit <= 1'b0;
      bus.active_id <= '0;
      bus.ctl_busy <= 1'b0;
    end else begin
      state <= state_n;
      rr <= rr_n;
      timer <= timer_n;
      bus.ack <= ack_n;
      bus.timeout_err <= terr_n;
      bus.uart_data_in <= data_n;
      bus.uart_transmit <= tx_n;
      bus.active_id <= id_n;
      bus.ctl_busy <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven and scoreboarded bench for uart_tx_arbiter with a uart_tx busy model
module tb_uart_tx_arbiter;
  localparam int NREQ = 4, DW = 8, TMO = 16, FRAME = 6;
  typedef struct {
    logic [3:0]  req;
    bit          hold;
    int          n;
    logic [31:0] ord;
    logic [7:0]  base;
  } vec_t;
  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    bit         to;
  } exp_t;
  logic clk = 0, reset = 0;
  int checks = 0, failures = 0;
  exp_t sb[$];
  vec_t vt[8];
  bit model_en = 1, force_busy = 0;
  int phase = 0, cnt = 0;
  uart_tx_arbiter_if #(.NREQ(NREQ), .DATA_W(DW)) bus ();
  uart_tx_arbiter #(.NREQ(NREQ), .DATA_W(DW), .START_TIMEOUT(TMO)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  function automatic exp_t mk(logic [1:0] id, logic [7:0] d, bit to);
    exp_t e;
    e.id = id;
    e.data = d;
    e.to = to;
    return e;
  endfunction
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic set_data(logic [7:0] base);
    for (int i = 0; i < NREQ; i++) bus.req_data[i*DW +: DW] = base + 8'(i);
  endtask
  task automatic serve(string nm, bit hold, int n);
    int k = 0, got = 0;
    while (bus.req != 0 && k < 400) begin
      @(negedge clk);
      k++;
      if (bus.ack != 0) begin
        got++;
        if (hold) begin
          if (got == n) bus.req = '0;
        end else bus.req = bus.req & ~bus.ack;
      end
    end
    chk({nm, "_served"}, k < 400, 1);
  endtask
  task automatic wait_idle(string nm);
    int k = 0;
    while ((sb.size() != 0 || bus.ctl_busy || bus.uart_tx_busy) && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_idle"}, k < 400, 1);
  endtask
  initial begin
    bus.uart_tx_busy = 0;
    forever begin
      @(posedge clk);
      #2;
      if (force_busy) bus.uart_tx_busy = 1;
      else if (!model_en) begin
        bus.uart_tx_busy = 0;
        phase = 0;
      end else if (phase == 0) begin
        bus.uart_tx_busy = 0;
        if (bus.uart_transmit) begin
          cnt = 1;
          phase = 1;
        end
      end else if (phase == 1) begin
        cnt++;
        if (cnt == 3) begin
          bus.uart_tx_busy = 1;
          cnt = 0;
          phase = 2;
        end
      end else begin
        cnt++;
        if (cnt == FRAME) begin
          bus.uart_tx_busy = 0;
          phase = 0;
        end
      end
    end
  end
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && (bus.ack != 0 || bus.timeout_err)) begin
        chk("ack_onehot", $onehot0(bus.ack), 1);
        if (sb.size() == 0) chk("unexpected_event", {27'd0, bus.timeout_err, bus.ack}, 0);
        else begin
          e = sb.pop_front();
          chk("ack_vec", bus.ack, e.to ? 4'd0 : 4'd1 << e.id);
          chk("timeout_flag", bus.timeout_err, e.to);
          chk("active_id", bus.active_id, e.id);
          chk("data_in", bus.uart_data_in, e.data);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    int k;
    vt[0] = vec_t'{4'b1111, 1'b1, 5, 32'h03210, 8'hA0};
    vt[1] = vec_t'{4'b0001, 1'b0, 1, 32'h0, 8'h55};
    vt[2] = vec_t'{4'b0101, 1'b0, 2, 32'h02, 8'hB0};
    vt[3] = vec_t'{4'b1010, 1'b0, 2, 32'h31, 8'hC0};
    vt[4] = vec_t'{4'b0110, 1'b0, 2, 32'h21, 8'hD0};
    vt[5] = vec_t'{4'b1001, 1'b0, 2, 32'h03, 8'hE0};
    vt[6] = vec_t'{4'b1111, 1'b0, 4, 32'h0321, 8'hF0};
    vt[7] = vec_t'{4'b1000, 1'b0, 1, 32'h3, 8'h10};
    bus.req = '0;
    bus.req_data = '0;
    cyc(3);
    chk("rst_ack", bus.ack, 0);
    chk("rst_timeout_err", bus.timeout_err, 0);
    chk("rst_data_in", bus.uart_data_in, 0);
    chk("rst_transmit", bus.uart_transmit, 0);
    chk("rst_active_id", bus.active_id, 0);
    chk("rst_ctl_busy", bus.ctl_busy, 0);
    reset = 1;
    cyc(2);
    chk("idle_transmit", bus.uart_transmit, 0);
    set_data(8'h55);
    sb.push_back(mk(0, 8'h55, 0));
    bus.req = 4'b0001;
    cyc(1);
    chk("A_tx_latency", bus.uart_transmit, 1);
    chk("A_data_in", bus.uart_data_in, 8'h55);
    chk("A_active_id", bus.active_id, 0);
    chk("A_ctl_busy", bus.ctl_busy, 1);
    k = 0;
    while (bus.ack == 0 && k < 50) begin
      cyc(1);
      k++;
    end
    chk("A_ack_seen", k < 50, 1);
    bus.req = '0;
    chk("A_tx_low_at_ack", bus.uart_transmit, 0);
    cyc(1);
    chk("A_ack_single", bus.ack, 0);
    k = 0;
    while (bus.uart_tx_busy && k < 50) begin
      cyc(1);
      k++;
    end
    chk("A_busy_fell", k < 50, 1);
    chk("A_ctl_busy_c0", bus.ctl_busy, 1);
    cyc(1);
    chk("A_ctl_busy_c1", bus.ctl_busy, 1);
    cyc(1);
    chk("A_ctl_busy_c2", bus.ctl_busy, 0);
    reset = 0;
    cyc(1);
    reset = 1;
    cyc(1);
    for (int v = 0; v < 8; v++) begin
      set_data(vt[v].base);
      for (int g = 0; g < vt[v].n; g++)
        sb.push_back(mk(vt[v].ord[4*g +: 2], vt[v].base + 8'(vt[v].ord[4*g +: 2]), 1'b0));
      bus.req = vt[v].req;
      serve($sformatf("vec%0d", v), vt[v].hold, vt[v].n);
      wait_idle($sformatf("vec%0d", v));
    end
    model_en = 0;
    cyc(2);
    bus.req_data = '0;
    bus.req_data[7:0] = 8'h11;
    bus.req_data[15:8] = 8'h22;
    sb.push_back(mk(0, 8'h11, 1));
    sb.push_back(mk(1, 8'h22, 0));
    sb.push_back(mk(0, 8'h11, 0));
    bus.req = 4'b0011;
    k = 0;
    while (!bus.uart_transmit && k < 20) begin
      cyc(1);
      k++;
    end
    chk("T_tx_seen", k < 20, 1);
    k = 0;
    do begin
      cyc(1);
      k++;
    end while (!bus.timeout_err && k < 40);
    chk("T_latency", k, TMO);
    chk("T_tx_low", bus.uart_transmit, 0);
    model_en = 1;
    cyc(1);
    chk("T_pulse_single", bus.timeout_err, 0);
    serve("T", 0, 0);
    wait_idle("T");
    force_busy = 1;
    cyc(2);
    reset = 0;
    set_data(8'h60);
    sb.push_back(mk(1, 8'h61, 0));
    bus.req = 4'b0010;
    cyc(2);
    reset = 1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("B_hold_tx", bus.uart_transmit, 0);
    end
    force_busy = 0;
    k = 0;
    while (bus.uart_tx_busy && k < 10) begin
      cyc(1);
      k++;
    end
    chk("B_busy_fell", k < 10, 1);
    chk("B_tx_still_low", bus.uart_transmit, 0);
    cyc(1);
    chk("B_tx_after_busy", bus.uart_transmit, 1);
    chk("B_active_id", bus.active_id, 1);
    serve("B", 0, 0);
    wait_idle("B");
    set_data(8'h70);
    sb.push_back(mk(2, 8'h72, 0));
    bus.req = 4'b0100;
    k = 0;
    while (bus.ack == 0 && k < 50) begin
      cyc(1);
      k++;
    end
    chk("C_ack_seen", k < 50, 1);
    bus.req = '0;
    reset = 0;
    cyc(1);
    reset = 1;
    chk("C_rst_ack", bus.ack, 0);
    chk("C_rst_timeout_err", bus.timeout_err, 0);
    chk("C_rst_data_in", bus.uart_data_in, 0);
    chk("C_rst_transmit", bus.uart_transmit, 0);
    chk("C_rst_active_id", bus.active_id, 0);
    chk("C_rst_ctl_busy", bus.ctl_busy, 0);
    chk("C_frame_inflight", bus.uart_tx_busy, 1);
    set_data(8'h80);
    for (int g = 0; g < NREQ; g++) sb.push_back(mk(2'(g), 8'h80 + 8'(g), 0));
    bus.req = 4'b1111;
    k = 0;
    while (bus.uart_tx_busy && k < 20) begin
      chk("C_wait_tx", bus.uart_transmit, 0);
      cyc(1);
      k++;
    end
    chk("C_busy_fell", k < 20, 1);
    cyc(1);
    chk("C_tx_after_busy", bus.uart_transmit, 1);
    chk("C_active_id", bus.active_id, 0);
    serve("C", 0, 0);
    wait_idle("C");
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
